// File: rtl/instr_mem_sync_if.sv
// -----------------------------------------------------------------------------
// instr_mem_sync_if
// Bundles the fetch, response and program-load signals of the synchronous
// instruction memory.
//   master : pipeline / bootloader side (drives requests and load writes)
//   slave  : memory side (drives Instruction, instr_valid, addr_fault, ready)
// Signals:
//   fetch_req   fetch request, sampled at the rising edge
//   Address     byte address from the PC
//   stall       pipeline stall, holds the current response
//   Instruction registered fetched word
//   instr_valid Instruction holds a response to an accepted fetch
//   addr_fault  current response is out of range or misaligned
//   ready       memory is in normal fetch mode
//   load_en     request/hold program-load mode
//   load_we     write strobe for program load
//   load_addr   word index to write
//   load_data   word to write
// -----------------------------------------------------------------------------
interface instr_mem_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  fetch_req;
  logic [31:0]           Address;
  logic                  stall;
  logic [DATA_WIDTH-1:0] Instruction;
  logic                  instr_valid;
  logic                  addr_fault;
  logic                  ready;
  logic                  load_en;
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;

  modport master (
    output fetch_req, Address, stall, load_en, load_we, load_addr, load_data,
    input  Instruction, instr_valid, addr_fault, ready
  );

  modport slave (
    input  fetch_req, Address, stall, load_en, load_we, load_addr, load_data,
    output Instruction, instr_valid, addr_fault, ready
  );
endinterface

// File: rtl/instr_mem_sync.sv
// -----------------------------------------------------------------------------
// instr_mem_sync
// Synchronous instruction memory for the pipelined MIPS core. One-cycle
// registered fetch with stall hold and fault flagging, a program-load port
// written by the UART bootloader, and an optional post-reset sweep that fills
// the array with NOP_WORD.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    instr_mem_sync_if.slave (fetch, response and load signals)
// Modes: CLEAR (sweep), RUN (fetches served, ready=1), LOAD (program writes).
// -----------------------------------------------------------------------------
module instr_mem_sync #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  instr_mem_sync_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Which source drives Instruction: reset value, RAM read register or NOP.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_NOP  = 2'd2
  } out_sel_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  out_sel_t              r_out_sel;
  logic                  r_valid;
  logic                  r_fault;

  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_fault;
  logic                  w_accept;
  logic                  w_rd_en;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // ---------------------------------------------------------------------------
  // Fetch decode
  // ---------------------------------------------------------------------------
  assign w_index  = bus.Address[ADDR_WIDTH+1:2];
  // Misaligned byte address, or any bit above the word-index field set.
  assign w_fault  = (bus.Address[1:0] != 2'b00) ||
                    (bus.Address[31:ADDR_WIDTH+2] != '0);
  // Stall wins over fetch_req; fetches only count in RUN.
  assign w_accept = (r_state == ST_RUN) && bus.fetch_req && !bus.stall;
  // A faulting fetch never touches the array.
  assign w_rd_en  = w_accept && !w_fault;

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_CLEAR) begin
        // Wraps back to 0 after the last index, ready for the next sweep.
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_mem_waddr  = r_clr_cnt;
    w_mem_wdata  = NOP_WORD;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we = 1'b1;
        if (&r_clr_cnt) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.load_en) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The write strobe is honoured even in the cycle load_en drops.
        if (bus.load_we) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = bus.load_addr;
          w_mem_wdata = bus.load_data;
        end
        if (!bus.load_en) begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: one synchronous write port, one synchronous read port.
  // Reads and writes are exclusive by mode, so no collision handling.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the array and its read register carry no reset so they map onto
    // block RAM; contents after reset come from the sweep or the loader.
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[w_index];
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_sel <= SEL_ZERO;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!bus.stall) begin
            if (bus.fetch_req) begin
              r_out_sel <= w_fault ? SEL_NOP : SEL_RAM;
              r_valid   <= 1'b1;
              r_fault   <= w_fault;
            end else begin
              // Idle: Instruction keeps its last value via r_out_sel.
              r_valid <= 1'b0;
              r_fault <= 1'b0;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.Instruction = '0;
    case (r_out_sel)
      SEL_RAM: bus.Instruction = r_rd_data;
      SEL_NOP: bus.Instruction = NOP_WORD;
      default: bus.Instruction = '0;
    endcase
  end

  assign bus.instr_valid = r_valid;
  assign bus.addr_fault  = r_fault;
  assign bus.ready       = (r_state == ST_RUN);

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Synchronous, parametrised instruction memory for the pipelined MIPS core. Successor to the single-cycle combinational instruction ROM.
- Registered 1-cycle read with fetch request, stall hold and out-of-range/misalignment fault flagging.
- Runtime program-load port, driven by the UART bootloader, replaces hard-coded contents.
- Optional post-reset clear sweep fills memory with NOP.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- ADDR_WIDTH, 8, word-index width; DEPTH = 2**ADDR_WIDTH words.
- CLEAR_ON_RESET, 1, 1 = run clear sweep after reset; 0 = go straight to RUN.
- NOP_WORD, 32'h00000000, word returned on fault and written by the clear sweep.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request, sampled at the rising edge.
- Address  in  32  byte address from PC; word index = Address[ADDR_WIDTH+1:2].
- stall  in  1  pipeline stall; holds the current response.
- Instruction  out  DATA_WIDTH  registered fetched word.
- instr_valid  out  1  Instruction holds a response to an accepted fetch.
- addr_fault  out  1  current response is out of range or misaligned.
- ready  out  1  high only in state RUN.
- load_en  in  1  request/hold LOAD mode.
- load_we  in  1  write strobe, honoured only in LOAD.
- load_addr  in  ADDR_WIDTH  word index to write.
- load_data  in  DATA_WIDTH  word to write.

Behaviour:
- Reset (reset=0, asynchronous):
  - Instruction=0, instr_valid=0, addr_fault=0.
  - State = CLEAR if CLEAR_ON_RESET=1, else RUN; ready follows state.
  - Clear counter = 0.
  - Memory array is not reset.
- State CLEAR:
  - Each cycle writes NOP_WORD to mem[cnt], then cnt++.
  - After writing index DEPTH-1, moves to RUN; the sweep takes exactly DEPTH cycles.
  - fetch_req, load_en and load_we are ignored; instr_valid=0.
- State RUN, acceptance: a fetch is accepted when fetch_req=1 and stall=0.
  - Next edge: Instruction = mem[index], instr_valid=1, addr_fault=0 (latency 1).
- RUN, faults:
  - Fault when Address[1:0]!=0, or any of Address[31:ADDR_WIDTH+2] is nonzero.
  - On fault: Instruction=NOP_WORD, instr_valid=1, addr_fault=1, memory not read.
- RUN, idle: when fetch_req=0 and stall=0, the next edge gives instr_valid=0 and addr_fault=0. Instruction holds its last value.
- RUN, stall: stall=1 holds Instruction, instr_valid and addr_fault unchanged, regardless of fetch_req. stall has priority over fetch_req.
- RUN to LOAD:
  - When load_en=1, state becomes LOAD at the next edge.
  - A fetch accepted in that same cycle still completes normally (its response appears at that edge).
- State LOAD:
  - instr_valid=0 and addr_fault=0 from the first LOAD cycle; fetches ignored; ready=0.
  - load_we=1 writes mem[load_addr]=load_data at the edge.
  - load_en=0 returns to RUN at the next edge; a load_we sampled in that same cycle is still written.
  - No read/write collision exists, since reads and writes are mutually exclusive by state.
- load_we outside LOAD: ignored, no write.
- Reset mid-CLEAR: sweep restarts at index 0.
- Reset mid-LOAD: load aborts. Already-written words are kept when CLEAR_ON_RESET=0 and wiped by the sweep when CLEAR_ON_RESET=1.
- Memory maps to block RAM: one synchronous write port and one synchronous read port, no reset on the array.

Test Plan:
- Reset then CLEAR_ON_RESET=1, DEPTH=256 -> ready=0 for exactly 256 cycles, then 1. Fetch of 0x0000_0040 returns 0x00000000 with instr_valid=1, addr_fault=0.
- LOAD load_addr=16 data=0x0C00000F, load_addr=17 data=0x3C0D4000; drop load_en; fetch 0x40 then 0x44 back-to-back -> Instruction 0x0C00000F then 0x3C0D4000 on consecutive cycles, each one cycle after its request.
- Fetch 0x44, then assert stall for 3 cycles while Address changes to 0x48 -> Instruction stays 0x3C0D4000 with instr_valid=1 all 3 cycles; 0x48's word appears one cycle after stall drops.
- Fetch 0x0000_0042 and 0x0000_0400 (ADDR_WIDTH=8) -> Instruction=NOP_WORD, addr_fault=1, instr_valid=1 for each; next fetch of 0x40 clears addr_fault.
- Assert load_en in the same cycle as a fetch of 0x40 -> that fetch's response appears, then instr_valid=0 and ready=0. load_we with load_en low in RUN -> memory unchanged on readback.
- Pull reset low for 1 cycle at sweep index 100 -> outputs zero immediately; a full 256-cycle sweep restarts from 0.
